// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding/hazard controller: select codes, shadow-stage record, FSM states.
package hazard_pkg;
  // Widest register address supported; narrower addresses are zero-extended into stage records.
  localparam int MAX_RA_W = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [MAX_RA_W-1:0] rd;
    logic                we;
    logic                is_load;
  } stage_t;

  typedef enum logic {ST_RUN, ST_MEM_WAIT} fsm_t;

  // x0 is hard-wired zero, so it never counts as a producer.
  function automatic logic writer_match(stage_t s, logic [MAX_RA_W-1:0] a);
    return s.valid & s.we & (s.rd == a) & (a != '0);
  endfunction
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decoder-side bundle of the forwarding/hazard controller.
// HAZ_PERF_CNT_EN adds the stall_cnt performance counter.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NSRC       = 2
);
  logic                       id_valid;
  logic [NSRC*REG_ADDR_W-1:0] id_src_addr;
  logic [NSRC-1:0]            id_src_used;
  logic [REG_ADDR_W-1:0]      id_rd_addr;
  logic                       id_rd_we;
  logic                       id_is_load;
  logic                       flush;
  logic                       mem_ready;
  logic [NSRC*2-1:0]          fwd_sel;
  logic                       stall_if_id;
  logic                       bubble_ex;
  logic                       freeze;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]                stall_cnt;
`endif

  modport master (
    output id_valid, id_src_addr, id_src_used, id_rd_addr, id_rd_we, id_is_load, flush, mem_ready,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt,
`endif
    input  fwd_sel, stall_if_id, bubble_ex, freeze
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_rd_addr, id_rd_we, id_is_load, flush, mem_ready,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt,
`endif
    output fwd_sel, stall_if_id, bubble_ex, freeze
  );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// One source operand compared against the EX and MEM shadow entries.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_used,
  input  stage_t                i_ex,
  input  stage_t                i_mem,
  output logic [1:0]            o_sel,
  output logic                  o_load_use
);
  logic [MAX_RA_W-1:0] w_src;
  logic                w_hit_ex;
  logic                w_hit_mem;

  assign w_src     = MAX_RA_W'(i_src);
  assign w_hit_ex  = i_used & writer_match(i_ex, w_src);
  assign w_hit_mem = i_used & writer_match(i_mem, w_src);

  // The younger producer (EX) shadows an older one in MEM.
  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_ex)       o_sel = FWD_MEM;
    else if (w_hit_mem) o_sel = FWD_WB;
  end

  assign o_load_use = w_hit_ex & i_ex.is_load;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and memory-wait freeze for the 5-stage core.
// HAZ_PERF_CNT_EN adds a saturating 32-bit stall/freeze cycle counter.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NSRC       = 2
) (
  input  logic            clk,
  input  logic            rst,
  fwd_hazard_ctrl_if.slave io
);
  // The WB shadow is not kept: nothing forwards out of it, the register file covers that case.
  stage_t                 r_ex;
  stage_t                 r_mem;
  logic [NSRC-1:0][1:0]   r_fwd_sel;
  fsm_t                   r_state;

  logic [NSRC-1:0][1:0]   w_sel;
  logic [NSRC-1:0]        w_lu;
  logic                   w_freeze;
  logic                   w_stall;
  logic                   w_bubble;
  stage_t                 w_id_entry;

  for (genvar g = 0; g < NSRC; g++) begin : g_op
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
      .i_src      (io.id_src_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .i_used     (io.id_src_used[g]),
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .o_sel      (w_sel[g]),
      .o_load_use (w_lu[g])
    );
  end

  assign w_freeze = r_mem.valid & r_mem.is_load & ~io.mem_ready;
  // A flushed consumer never stalls; freeze overrides any stall request.
  assign w_stall  = ~w_freeze & io.id_valid & ~io.flush & (|w_lu);
  assign w_bubble = ~io.id_valid | io.flush | w_stall;

  always_comb begin
    w_id_entry         = '0;
    w_id_entry.valid   = ~w_bubble;
    w_id_entry.rd      = MAX_RA_W'(io.id_rd_addr);
    w_id_entry.we      = io.id_rd_we;
    w_id_entry.is_load = io.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_fwd_sel <= '0;
    end else if (!w_freeze) begin
      r_mem     <= r_ex;
      r_ex      <= w_id_entry;
      r_fwd_sel <= w_bubble ? '0 : w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else begin
      case (r_state)
        ST_RUN:      if (w_freeze)     r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (io.mem_ready) r_state <= ST_RUN;
        default:                       r_state <= ST_RUN;
      endcase
    end
  end

  assign io.fwd_sel     = r_fwd_sel;
  assign io.stall_if_id = w_stall;
  assign io.bubble_ex   = w_stall;
  assign io.freeze      = w_freeze;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else if ((w_freeze | w_stall) && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign io.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed test-plan scenarios plus random traffic against an in-flight instruction list model.
module tb_fwd_hazard_ctrl;
  localparam int RAW = 5;
  localparam int NS  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(RAW), .NSRC(NS)) io ();
  fwd_hazard_ctrl #(.REG_ADDR_W(RAW), .NSRC(NS)) dut (.clk(clk), .rst(rst), .io(io));

  // In-flight instructions, youngest first: slot 0 is one instruction ahead of ID, slot 1 two ahead.
  typedef struct { bit v; int rd; bit we; bit ld; } ent_t;
  ent_t        m_stg[2];
  int          m_sel[NS];
  bit   [31:0] m_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  bit obs_stall, obs_bub, obs_frz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Distance to the nearest older producer of register a (1 or 2), 0 if none in flight.
  function automatic int dist_of(input int a);
    for (int d = 0; d < 2; d++)
      if (m_stg[d].v && m_stg[d].we && m_stg[d].rd == a && a != 0) return d + 1;
    return 0;
  endfunction

  function automatic logic [3:0] exp_sel();
    logic [3:0] r;
    for (int i = 0; i < NS; i++) r[2*i +: 2] = 2'(m_sel[i]);
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) m_stg[d] = '{0, 0, 0, 0};
    for (int i = 0; i < NS; i++) m_sel[i] = 0;
    m_cnt = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit [4:0] s0, input bit [4:0] s1,
                      input bit [1:0] u, input bit [4:0] rd, input bit we, input bit ld,
                      input bit fl, input bit mr);
    int  src[NS];
    int  nsel[NS];
    bit  e_frz, e_lu, e_stall, issue;
    @(negedge clk);
    rst = r;
    io.id_valid = v; io.id_src_addr = {s1, s0}; io.id_src_used = u;
    io.id_rd_addr = rd; io.id_rd_we = we; io.id_is_load = ld;
    io.flush = fl; io.mem_ready = mr;
    #1;
    src[0] = int'(s0); src[1] = int'(s1);
    e_frz = m_stg[1].v && m_stg[1].ld && !mr;
    e_lu  = 1'b0;
    for (int i = 0; i < NS; i++)
      if (u[i] && dist_of(src[i]) == 1 && m_stg[0].ld) e_lu = 1'b1;
    e_stall = !e_frz && v && !fl && e_lu;
    obs_stall = io.stall_if_id; obs_bub = io.bubble_ex; obs_frz = io.freeze;
    chk("freeze",  32'(io.freeze),      32'(e_frz));
    chk("stall",   32'(io.stall_if_id), 32'(e_stall));
    chk("bubble",  32'(io.bubble_ex),   32'(e_stall));
    chk("fwd_sel", 32'(io.fwd_sel),     32'(exp_sel()));
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", io.stall_cnt, m_cnt);
`endif
    issue = v && !fl && !e_stall;
    for (int i = 0; i < NS; i++) nsel[i] = (issue && u[i]) ? dist_of(src[i]) : 0;
    @(posedge clk);
    if (r) model_clear();
    else begin
      if ((e_frz || e_stall) && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (!e_frz) begin
        m_sel    = nsel;
        m_stg[1] = m_stg[0];
        m_stg[0] = '{issue, int'(rd), we, ld};
      end
    end
  endtask

  task automatic nop(input bit mr);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, mr);
  endtask

  initial begin
    io.id_valid = 0; io.id_src_addr = '0; io.id_src_used = '0; io.id_rd_addr = '0;
    io.id_rd_we = 0; io.id_is_load = 0; io.flush = 0; io.mem_ready = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd",    32'(io.fwd_sel),     0);
    chk("rst_stall",  32'(io.stall_if_id), 0);
    chk("rst_bubble", 32'(io.bubble_ex),   0);
    chk("rst_freeze", 32'(io.freeze),      0);
    rst = 0;

    // back-to-back ALU: add x5 ; add x6,x5,x1
    step(0, 1, 1, 2, 2'b11, 5, 1, 0, 0, 1);
    step(0, 1, 5, 1, 2'b11, 6, 1, 0, 0, 1);
    #1 chk("b2b_sel", 32'(io.fwd_sel), 32'h1);
    nop(1); nop(1);

    // one-gap: add x5 ; nop ; sub x7,x5,x5
    step(0, 1, 1, 2, 2'b11, 5, 1, 0, 0, 1);
    nop(1);
    step(0, 1, 5, 5, 2'b11, 7, 1, 0, 0, 1);
    #1 chk("gap_sel", 32'(io.fwd_sel), 32'hA);
    nop(1); nop(1);

    // load-use: lw x3 ; add x4,x3,x2
    step(0, 1, 1, 0, 2'b01, 3, 1, 1, 0, 1);
    step(0, 1, 3, 2, 2'b11, 4, 1, 0, 0, 1);
    chk("lu_stall", 32'(obs_stall), 1);
    chk("lu_bub",   32'(obs_bub),   1);
    step(0, 1, 3, 2, 2'b11, 4, 1, 0, 0, 1);
    chk("lu_once", 32'(obs_stall), 0);
    #1 chk("lu_sel", 32'(io.fwd_sel[1:0]), 32'h2);
    nop(1); nop(1);

    // memory wait of three cycles
    step(0, 1, 1, 0, 2'b01, 3, 1, 1, 0, 1);
    step(0, 1, 3, 0, 2'b01, 8, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      nop(0);
      chk("mw_freeze", 32'(obs_frz), 1);
    end
    nop(1);
    chk("mw_release", 32'(obs_frz), 0);
    nop(1); nop(1);

    // x0 never forwards or stalls
    step(0, 1, 1, 0, 2'b01, 0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 2'b11, 9, 1, 0, 0, 1);
    chk("x0_stall", 32'(obs_stall), 0);
    #1 chk("x0_sel", 32'(io.fwd_sel), 0);
    nop(1); nop(1);

    // flush with load-use: flush wins
    step(0, 1, 1, 0, 2'b01, 3, 1, 1, 0, 1);
    step(0, 1, 3, 3, 2'b11, 4, 1, 0, 1, 1);
    chk("fl_stall", 32'(obs_stall), 0);
    chk("fl_bub",   32'(obs_bub),   0);
    #1 chk("fl_sel", 32'(io.fwd_sel), 0);
    nop(1); nop(1);

    // reset during memory wait
    step(0, 1, 1, 0, 2'b01, 3, 1, 1, 0, 1);
    nop(1);
    nop(0);
    chk("rmw_frz", 32'(obs_frz), 1);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    chk("rmw_freeze", 32'(io.freeze),      0);
    chk("rmw_stall",  32'(io.stall_if_id), 0);
    chk("rmw_fwd",    32'(io.fwd_sel),     0);
`ifdef HAZ_PERF_CNT_EN
    chk("rmw_cnt", io.stall_cnt, 0);
`endif

    // random traffic over a small register window to provoke many hazards
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the 5-stage core; successor to the combinational forwarding mux-select logic. Tracks destination registers of in-flight instructions in internal EX/MEM/WB shadow stages. Produces registered per-operand forwarding selects for the EX stage, detects load-use hazards, and freezes the pipeline while a load in MEM waits on data memory. Sits beside the decoder and drives the ALU operand muxes and the pipeline-register enables.

## Interface
- REG_ADDR_W, 5, register address width
- NSRC, 2, source operands per instruction (1..3)

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  instruction in ID is valid
- id_src_addr  in  NSRC*REG_ADDR_W  source register addresses; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NSRC  operand i is actually read
- id_rd_addr  in  REG_ADDR_W  destination register
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  squash the instruction in ID (branch taken)
- mem_ready  in  1  data memory returns load data this cycle
- fwd_sel  out  NSRC*2  per-operand EX select: 00 register file, 01 EX/MEM result, 10 MEM/WB result
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- freeze  out  1  hold all pipeline registers

## Operation
- Shadow stages EX, MEM, WB; each holds {valid, rd, we, is_load}, plus NSRC captured source addresses and used bits in EX.
- Advance, when freeze=0: WB<=MEM, MEM<=EX, EX<=ID entry. The ID entry is a bubble if id_valid=0, flush=1 or stall_if_id=1.
- Writer match: stage valid & we & rd==addr & addr!=0. Register x0 is never forwarded and never causes a stall.
- Load-use: operand i used and matches a writer EX entry with is_load=1 -> stall_if_id=1, bubble_ex=1.
- fwd_sel per operand, computed at the advancing edge:
  - operand used and matches EX entry (becomes MEM) -> 01.
  - else matches MEM entry (becomes WB) -> 10.
  - else 00.
  - Younger stage wins.
- Combinational freeze = MEM.valid & MEM.is_load & ~mem_ready.
- FSM states:
  - RUN -> MEM_WAIT when freeze asserts.
  - MEM_WAIT -> RUN on the cycle mem_ready=1.
  - No other states.

## Timing
- Reset: all shadow valids 0; fwd_sel all 00; stall_if_id, bubble_ex, freeze 0; FSM RUN.
- fwd_sel is registered: valid in the cycle the instruction occupies EX, one clock after its ID cycle.
- stall_if_id, bubble_ex, freeze are combinational from current shadow state and ID inputs; they are valid in the same cycle.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM, the consumer is still in ID, and the consumer later receives fwd_sel=10.
- freeze=1: shadow stages, fwd_sel and FSM inputs hold. stall_if_id and bubble_ex are forced 0.
- flush is ignored while freeze=1; the upstream logic holds flush until freeze drops.
- flush together with load-use: flush wins; no stall, and a bubble enters EX.
- Bubble in EX: its fwd_sel is 00.
- rst mid-MEM_WAIT: all state clears on the next edge and freeze drops immediately after.

## Configuration
- HAZ_PERF_CNT_EN defined: adds a 32-bit output stall_cnt.
  - Increments once per cycle in which freeze or stall_if_id is 1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst.
- HAZ_PERF_CNT_EN undefined: no port and no counter logic.

## Structure
- hazard_pkg holds:
  - FWD_REG/FWD_MEM/FWD_WB select constants.
  - Stage record typedef {valid, rd, we, is_load}.
  - FSM state enum.
- Sub-module fwd_match: one operand's comparator against the EX and MEM entries, returning the 2-bit select plus a load-use flag. Instantiated NSRC times via generate.

## Test plan
- Back-to-back ALU dependency: add x5 in ID, then add x6,x5,x1 -> consumer sees fwd_sel[1:0]=01 in EX.
- Gap of one instruction: add x5, nop, sub x7,x5,x5 -> both operand selects =10.
- Load-use: lw x3, then add x4,x3,x2 -> stall_if_id=bubble_ex=1 for exactly one cycle, then fwd_sel[1:0]=10.
- Memory wait: lw in MEM with mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, fwd_sel held, FSM returns to RUN when mem_ready=1.
- x0 and flush:
  - add x0 followed by a use of x0 -> fwd_sel=00, no stall.
  - flush coincident with load-use -> no stall, EX bubble.
- Reset mid-freeze: assert rst during MEM_WAIT -> next cycle all outputs 0, and stall_cnt=0 when HAZ_PERF_CNT_EN is defined.
